// File: rtl/ysyx_pkg.sv
// Shared ysyx definitions: build-wide defaults, the ROB tag-width rule and the ROB entry record.
// The entry payload width follows `YSYX_XLEN, so ROB instances use the default XLEN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif

package ysyx_pkg;

  localparam int XLEN_DEFAULT     = `YSYX_XLEN;
  localparam int ROB_SIZE_DEFAULT = `YSYX_ROB_SIZE;
  localparam int NUM_ARCH_REGS    = 32;

  // Tag = entry index + 1, so one extra bit keeps tag 0 free for "no producer".
  function automatic int tag_width(input int rob_size);
    return $clog2(rob_size) + 1;
  endfunction

  localparam int ROB_TW_DEFAULT = tag_width(ROB_SIZE_DEFAULT);

  typedef struct packed {
    logic [4:0]              rd;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pnpc;
    logic [31:0]             inst;
    logic [XLEN_DEFAULT-1:0] result;
    logic [XLEN_DEFAULT-1:0] npc;
    logic                    busy;
    logic                    done;
  } rob_entry_t;

endpackage

// File: rtl/ysyx_rob_rat.sv
// Register rename table: one producer tag per architectural register, 0 = value is in the RF.
// Supports a full clear (flush), a conditional clear (commit) and a set (allocation, which wins).
module ysyx_rob_rat
  import ysyx_pkg::*;
#(
  parameter int TW = ROB_TW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_all,
  input  logic          set_en,
  input  logic [4:0]    set_rd,
  input  logic [TW-1:0] set_tag,
  input  logic          clr_en,
  input  logic [4:0]    clr_rd,
  input  logic [TW-1:0] clr_tag,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic [TW-1:0] tag1,
  output logic [TW-1:0] tag2
);

  logic [TW-1:0] rat_q [NUM_ARCH_REGS];
  logic [TW-1:0] rat_d [NUM_ARCH_REGS];

  // NOTE: the whole next-state array is defaulted to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    rat_d = rat_q;
    if (clear_all) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) rat_d[i] = '0;
    end else begin
      if (clr_en && (rat_q[clr_rd] == clr_tag)) rat_d[clr_rd] = '0;
      // Applied after the clear so a same-cycle rename of the committing rd survives.
      if (set_en && (set_rd != 5'd0)) rat_d[set_rd] = set_tag;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) rat_q[i] <= '0;
    end else begin
      rat_q <= rat_d;
    end
  end

  // x0 is never renamed, so rat_q[0] stays zero.
  assign tag1 = rat_q[rs1];
  assign tag2 = rat_q[rs2];

endmodule

// File: rtl/ysyx_rob.sv
// Reorder buffer: in-order allocation and commit, out-of-order writeback, operand rename lookup
// and mispredict flush when a committing entry's resolved next PC differs from its prediction.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif

module ysyx_rob
  import ysyx_pkg::*;
#(
  parameter  int ROB_SIZE = `YSYX_ROB_SIZE,
  parameter  int XLEN     = `YSYX_XLEN,
  localparam int TW       = tag_width(ROB_SIZE)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [4:0]      alloc_rd,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic [XLEN-1:0] alloc_pnpc,
  input  logic [31:0]     alloc_inst,
  output logic [TW-1:0]   alloc_dest,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [TW-1:0]   qj,
  output logic [TW-1:0]   qk,
  output logic [XLEN-1:0] vj,
  output logic [XLEN-1:0] vk,
  input  logic            wb_valid,
  input  logic [TW-1:0]   wb_dest,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] wb_npc,
  output logic            rf_wen,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [31:0]     commit_inst,
  output logic            flush,
  output logic [XLEN-1:0] flush_pc
);

  localparam int IW = TW - 1;
  typedef logic [IW-1:0] idx_t;

  rob_entry_t    entries_q [ROB_SIZE];
  rob_entry_t    entries_d [ROB_SIZE];
  idx_t          head_q, head_d, tail_q, tail_d;
  logic [TW-1:0] count_q, count_d;

  rob_entry_t    head_e;
  logic          commit_fire, mispredict, alloc_fire, wb_hit;
  idx_t          wb_idx, src1_idx, src2_idx;
  logic [TW-1:0] commit_tag, src1_tag, src2_tag;

  assign head_e      = entries_q[head_q];
  assign commit_fire = head_e.busy & head_e.done;
  assign mispredict  = commit_fire & (head_e.npc != head_e.pnpc);
  assign commit_tag  = {1'b0, head_q} + TW'(1);

  // Only registered count is used: a commit in this cycle does not open a slot until the next one.
  assign alloc_ready = (count_q < TW'(ROB_SIZE)) & ~mispredict;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_dest  = {1'b0, tail_q} + TW'(1);

  assign wb_idx = idx_t'(wb_dest - TW'(1));
  assign wb_hit = wb_valid & (wb_dest != '0) & (wb_dest <= TW'(ROB_SIZE)) & entries_q[wb_idx].busy;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (mispredict) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) begin
        entries_d[tail_q] = '{rd: alloc_rd, pc: alloc_pc, pnpc: alloc_pnpc, inst: alloc_inst,
                              result: '0, npc: '0, busy: 1'b1, done: 1'b0};
        tail_d = tail_q + idx_t'(1);
      end
      if (wb_hit) begin
        entries_d[wb_idx].done   = 1'b1;
        entries_d[wb_idx].result = wb_result;
        entries_d[wb_idx].npc    = wb_npc;
      end
      if (commit_fire) begin
        entries_d[head_q].busy = 1'b0;
        entries_d[head_q].done = 1'b0;
        head_d = head_q + idx_t'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + TW'(1);
        2'b01:   count_d = count_q - TW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the entry array is reset in full; busy/done must clear immediately, and zeroing the payload keeps it deterministic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  ysyx_rob_rat #(.TW(TW)) u_rat (
    .clock     (clock),
    .reset     (reset),
    .clear_all (mispredict),
    .set_en    (alloc_fire),
    .set_rd    (alloc_rd),
    .set_tag   (alloc_dest),
    .clr_en    (commit_fire),
    .clr_rd    (head_e.rd),
    .clr_tag   (commit_tag),
    .rs1       (rs1),
    .rs2       (rs2),
    .tag1      (src1_tag),
    .tag2      (src2_tag)
  );

  // A done producer forwards its result; a pending one hands out its tag.
  assign src1_idx = idx_t'(src1_tag - TW'(1));
  assign src2_idx = idx_t'(src2_tag - TW'(1));

  always_comb begin
    qj = '0;
    vj = '0;
    if ((src1_tag != '0) && entries_q[src1_idx].busy) begin
      if (entries_q[src1_idx].done) vj = entries_q[src1_idx].result;
      else                          qj = src1_tag;
    end
  end

  always_comb begin
    qk = '0;
    vk = '0;
    if ((src2_tag != '0) && entries_q[src2_idx].busy) begin
      if (entries_q[src2_idx].done) vk = entries_q[src2_idx].result;
      else                          qk = src2_tag;
    end
  end

  assign commit_valid = commit_fire;
  assign commit_pc    = head_e.pc;
  assign commit_inst  = head_e.inst;
  assign rf_wen       = commit_fire & (head_e.rd != 5'd0);
  assign rf_rd        = head_e.rd;
  assign rf_wdata     = head_e.result;
  assign flush        = mispredict;
  assign flush_pc     = head_e.npc;

endmodule
